// File: rtl/layer_pwr_seq.sv
// Power sequencer for stacked die layers: serialises per-layer power-up and power-down
// (switch enable, isolation clamps, retention save/restore) so only one rail toggles at a time.
module layer_pwr_seq #(
    parameter int NUM_LAYERS  = 4,
    parameter int SETTLE_CYC  = 8,
    parameter int TIMEOUT_CYC = 64,
    localparam int LW = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
    input  logic                  clk1,
    input  logic                  rst_n,
    input  logic [NUM_LAYERS-1:0] pwr_req,
    input  logic [NUM_LAYERS-1:0] pwr_ack,
    input  logic                  err_clr,
    output logic [NUM_LAYERS-1:0] pwr_en,
    output logic [NUM_LAYERS-1:0] iso_en,
    output logic [NUM_LAYERS-1:0] ret_save,
    output logic [NUM_LAYERS-1:0] ret_restore,
    output logic [NUM_LAYERS-1:0] layer_on,
    output logic                  busy,
    output logic [LW-1:0]         cur_layer,
    output logic [NUM_LAYERS-1:0] err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PU_SW,
        S_PU_SETTLE,
        S_PU_RESTORE,
        S_PU_UNISO,
        S_PD_ISO,
        S_PD_SAVE,
        S_PD_SW
    } state_e;

    localparam logic [7:0] TO_LAST  = 8'(TIMEOUT_CYC - 1);
    localparam logic [7:0] SET_LAST = 8'(SETTLE_CYC - 1);

    state_e                state_q, state_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [LW-1:0]         rr_q, rr_d;
    logic [LW-1:0]         cur_q, cur_d;
    logic [NUM_LAYERS-1:0] pwr_en_q, pwr_en_d;
    logic [NUM_LAYERS-1:0] iso_q, iso_d;
    logic [NUM_LAYERS-1:0] save_q, save_d;
    logic [NUM_LAYERS-1:0] rest_q, rest_d;
    logic [NUM_LAYERS-1:0] on_q, on_d;
    logic [NUM_LAYERS-1:0] err_q, err_d;
    logic                  busy_q, busy_d;

    logic [NUM_LAYERS-1:0] pending;
    logic [NUM_LAYERS-1:0] pick_mask;
    logic [NUM_LAYERS-1:0] cur_mask;
    logic [LW-1:0]         pick;
    logic                  pick_found;
    logic                  ack_k;

    // Layer index base+off, wrapped modulo NUM_LAYERS (works for non-power-of-two counts).
    function automatic logic [LW-1:0] rr_wrap(input logic [LW-1:0] base, input int unsigned off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= NUM_LAYERS) s = s - NUM_LAYERS;
        return LW'(s);
    endfunction

    // Round-robin arbitration: first pending layer after the last one served.
    always_comb begin
        pending    = (pwr_req ^ on_q) & ~err_q;
        pick       = '0;
        pick_found = 1'b0;
        for (int unsigned i = 1; i <= NUM_LAYERS; i++) begin
            if (!pick_found && pending[rr_wrap(rr_q, i)]) begin
                pick_found = 1'b1;
                pick       = rr_wrap(rr_q, i);
            end
        end
    end

    assign pick_mask = NUM_LAYERS'(1) << pick;
    assign cur_mask  = NUM_LAYERS'(1) << cur_q;
    assign ack_k     = pwr_ack[cur_q];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rr_d     = rr_q;
        cur_d    = cur_q;
        pwr_en_d = pwr_en_q;
        iso_d    = iso_q;
        on_d     = on_q;
        save_d   = '0;
        rest_d   = '0;
        err_d    = err_clr ? '0 : err_q;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (pick_found) begin
                    cur_d = pick;
                    rr_d  = pick;
                    if (!on_q[pick]) begin
                        pwr_en_d = pwr_en_q | pick_mask;
                        state_d  = S_PU_SW;
                    end else begin
                        iso_d   = iso_q | pick_mask;
                        on_d    = on_q & ~pick_mask;
                        state_d = S_PD_ISO;
                    end
                end
            end
            S_PU_SW: begin
                if (ack_k) begin
                    cnt_d   = '0;
                    state_d = S_PU_SETTLE;
                end else if (cnt_q == TO_LAST) begin
                    // Set wins over a simultaneous err_clr; clamps stay engaged.
                    err_d    = err_d | cur_mask;
                    pwr_en_d = pwr_en_q & ~cur_mask;
                    cnt_d    = '0;
                    state_d  = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_PU_SETTLE: begin
                if (cnt_q == SET_LAST) begin
                    cnt_d   = '0;
                    rest_d  = cur_mask;
                    state_d = S_PU_RESTORE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_PU_RESTORE: begin
                state_d = S_PU_UNISO;
            end
            S_PU_UNISO: begin
                iso_d   = iso_q & ~cur_mask;
                on_d    = on_q | cur_mask;
                state_d = S_IDLE;
            end
            S_PD_ISO: begin
                save_d  = cur_mask;
                state_d = S_PD_SAVE;
            end
            S_PD_SAVE: begin
                pwr_en_d = pwr_en_q & ~cur_mask;
                cnt_d    = '0;
                state_d  = S_PD_SW;
            end
            S_PD_SW: begin
                if (!ack_k) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else if (cnt_q == TO_LAST) begin
                    err_d   = err_d | cur_mask;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            rr_q     <= '0;
            cur_q    <= '0;
            pwr_en_q <= '0;
            iso_q    <= '1;
            save_q   <= '0;
            rest_q   <= '0;
            on_q     <= '0;
            err_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rr_q     <= rr_d;
            cur_q    <= cur_d;
            pwr_en_q <= pwr_en_d;
            iso_q    <= iso_d;
            save_q   <= save_d;
            rest_q   <= rest_d;
            on_q     <= on_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
        end
    end

    assign pwr_en      = pwr_en_q;
    assign iso_en      = iso_q;
    assign ret_save    = save_q;
    assign ret_restore = rest_q;
    assign layer_on    = on_q;
    assign busy        = busy_q;
    assign cur_layer   = cur_q;
    assign err         = err_q;

`ifndef SYNTHESIS
    // Safety invariants of the sequencing protocol.
    a_one_edge: assert property (@(posedge clk1) disable iff (!rst_n)
        $onehot0(pwr_en_q ^ $past(pwr_en_q)));
    a_iso_on: assert property (@(posedge clk1) disable iff (!rst_n)
        ((~iso_q & ~on_q) == '0));
    a_ret_excl: assert property (@(posedge clk1) disable iff (!rst_n)
        !((|save_q) && (|rest_q)));
    a_save_pulse: assert property (@(posedge clk1) disable iff (!rst_n)
        !((|save_q) && $past(|save_q)));
    a_rest_pulse: assert property (@(posedge clk1) disable iff (!rst_n)
        !((|rest_q) && $past(|rest_q)));
`endif

endmodule

// File: doc/layer_pwr_seq.md
Name: layer_pwr_seq

Overview:
Power sequencer for the stacked die layers (L0..L3) of the 3D design. It arbitrates per-layer power-on/off requests and serialises them so only one layer's switch toggles at a time, which limits inrush through shared TSV power rails. It drives each layer's power switch, isolation clamps on inter-layer signals, and retention save/restore. It sits in the always-on top-level region beside the layer instances and is clocked by clk1.

Parameters:
NUM_LAYERS, 4, number of power-gated layers sequenced (index 0..NUM_LAYERS-1)
SETTLE_CYC, 8, cycles waited after switch-on ack before restore (1..255)
TIMEOUT_CYC, 64, max cycles waiting for pwr_ack before flagging error (1..255)

Ports:
clk1  in  1  sequencer clock
rst_n  in  1  asynchronous active-low reset
pwr_req  in  NUM_LAYERS  level request per layer: 1 = want on, 0 = want off
pwr_ack  in  NUM_LAYERS  switch status from power switch chain: 1 = rail up
err_clr  in  1  synchronous clear of all err bits
pwr_en  out  NUM_LAYERS  power switch enable per layer
iso_en  out  NUM_LAYERS  isolation clamp enable per layer (1 = clamped)
ret_save  out  NUM_LAYERS  one-cycle retention save pulse
ret_restore  out  NUM_LAYERS  one-cycle retention restore pulse
layer_on  out  NUM_LAYERS  layer fully powered and unclamped
busy  out  1  sequence in progress (state != IDLE)
cur_layer  out  clog2(NUM_LAYERS)  layer currently being sequenced
err  out  NUM_LAYERS  sticky ack-timeout flag per layer

Behaviour:
- Clock and reset: single clock clk1; reset is asynchronous, active-low (rst_n). All outputs registered.
- Reset values: pwr_en=0, iso_en=all 1, ret_save=0, ret_restore=0, layer_on=0, busy=0, cur_layer=0, err=0, rr pointer=0, state=IDLE, counter=0. Reset asserted mid-sequence forces these values immediately; no partial sequence resumes.
- pending[k] = (pwr_req[k] != layer_on[k]) && !err[k].
- IDLE: if any pending, round-robin pick of k starting at rr+1 (mod NUM_LAYERS); cur_layer<=k, rr<=k, busy<=1.
  - If layer_on[k]=0, go to PU_SW with pwr_en[k]<=1.
  - Else go to PD_ISO with iso_en[k]<=1, layer_on[k]<=0.
- PU_SW: counter increments each cycle.
  - On pwr_ack[k]=1: counter<=0, go to PU_SETTLE.
  - If counter reaches TIMEOUT_CYC-1 without ack: err[k]<=1, pwr_en[k]<=0, go to IDLE (iso stays 1).
- PU_SETTLE: count SETTLE_CYC cycles, then ret_restore[k]=1 for exactly one cycle (state PU_RESTORE).
- PU_UNISO: iso_en[k]<=0, layer_on[k]<=1, go to IDLE.
- Power-up latency with immediate ack: pwr_en at cycle 1 after the IDLE decision, layer_on at cycle 1+1+SETTLE_CYC+2.
- PD_ISO: one cycle, then PD_SAVE (ret_save[k]=1, one cycle).
- PD_SW: pwr_en[k]<=0, counter increments.
  - On pwr_ack[k]=0: go to IDLE.
  - On timeout: err[k]<=1, go to IDLE; pwr_en stays 0 and layer_on stays 0.
- pwr_req changes during a sequence are ignored until IDLE re-evaluates; a request that toggles back before service causes no sequence.
- Only one pwr_en edge in flight at any time; busy=1 from the cycle after the IDLE decision through the final state.
- iso_en[k]=0 only while layer_on[k]=1. ret_save/ret_restore are never asserted together and never for two consecutive cycles.
- err_clr clears all err bits. If err_clr and a new timeout occur in the same cycle, the set wins for that bit.
- Layers with err=1 are skipped by arbitration until cleared.

Test Plan:
- Single power-up: SETTLE_CYC=8, pwr_req=0001, pwr_ack[0] rises 3 cycles after pwr_en[0] -> ret_restore[0] pulse 8 cycles after ack, then iso_en[0]=0, layer_on=0001, busy falls the cycle after.
- Round-robin: pwr_req 0000->1111 in one cycle with rr=0 -> layers sequenced in order 1,2,3,0; never two pwr_en rising in the same cycle.
- Power-down: layer 2 on, pwr_req[2]=0 -> iso_en[2]=1 and layer_on[2]=0, next cycle ret_save[2] pulse, next cycle pwr_en[2]=0; IDLE on pwr_ack[2]=0.
- Timeout: TIMEOUT_CYC=64, pwr_ack[1] held 0 -> err[1]=1 after 64 cycles, pwr_en[1]=0, layer 1 skipped; err_clr then re-attempts power-up.
- Reset mid-sequence: rst_n low during PU_SETTLE of layer 3 -> pwr_en=0, iso_en=1111, busy=0 in the same cycle; after release, sequencing restarts from IDLE.
- Request glitch: pwr_req[0] 0->1->0 while layer 2 is sequencing -> no sequence for layer 0.
